// File: rtl/fp_div_normalize_pkg.sv
// Shared types and exponent helpers for the divide-path normalize/round stage.
// Optional feature macro: FP_DIV_RNE_EN (round to nearest even; truncate when undefined).
package fpu_div_pkg;

   typedef struct packed {
      logic dz;
      logic overflow;
      logic underflow;
      logic inexact;
   } fp_flags_t;

   function automatic int exp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   function automatic int exp_ones(input int exp_w);
      return (1 << exp_w) - 1;
   endfunction

endpackage

// File: rtl/fp_div_normalize_if.sv
// Handshake bundle between the mantissa divider array, the normalize stage and its consumer.
// Optional feature macro: FP_DIV_RNE_EN (no effect on this interface).
interface fp_div_normalize_if #(
   parameter int FRAC_W = 3,
   parameter int EXP_W  = 4
);
   localparam int Q_W = FRAC_W + 3;

   logic                    in_valid;
   logic                    in_ready;
   logic [Q_W-1:0]          in_quot;
   logic                    in_rem_nz;
   logic signed [EXP_W+1:0] in_exp;
   logic                    in_sign;
   logic                    in_zero;
   logic                    in_dz;

   logic                    out_valid;
   logic                    out_ready;
   logic                    out_sign;
   logic [EXP_W-1:0]        out_exp;
   logic [FRAC_W-1:0]       out_frac;
   logic [3:0]              out_flags;

   modport master (
      output in_valid, in_quot, in_rem_nz, in_exp, in_sign, in_zero, in_dz,
      input  in_ready,
      input  out_valid, out_sign, out_exp, out_frac, out_flags,
      output out_ready
   );

   modport slave (
      input  in_valid, in_quot, in_rem_nz, in_exp, in_sign, in_zero, in_dz,
      output in_ready,
      output out_valid, out_sign, out_exp, out_frac, out_flags,
      input  out_ready
   );

endinterface

// File: rtl/fp_div_normalize_round.sv
// Combinational rounder: fraction (hidden bit implicit), guard, sticky -> rounded fraction, carry, inexact.
// Optional feature macro: FP_DIV_RNE_EN selects round-to-nearest-even; otherwise truncates.
module fp_div_round #(
   parameter int FRAC_W = 3
) (
   input  logic [FRAC_W-1:0] frac_i,
   input  logic              guard_i,
   input  logic              sticky_i,
   output logic [FRAC_W-1:0] frac_o,
   output logic              carry_o,
   output logic              inexact_o
);

   assign inexact_o = guard_i | sticky_i;

`ifdef FP_DIV_RNE_EN
   logic round_up;

   assign round_up = guard_i & (sticky_i | frac_i[0]);
   // Hidden bit is always 1, so a carry out of the fraction means 1.11..1 rounded to 10.00..0.
   assign {carry_o, frac_o} = {1'b0, frac_i} + (FRAC_W + 1)'(round_up);
`else
   assign frac_o  = frac_i;
   assign carry_o = 1'b0;
`endif

endmodule

// File: rtl/fp_div_normalize.sv
// Two-stage post-divide normalize (stage 1) and round/pack (stage 2) with valid/ready on both sides.
// Optional feature macro: FP_DIV_RNE_EN (round to nearest even; truncate when undefined).
module fp_div_normalize
   import fpu_div_pkg::*;
#(
   parameter int FRAC_W = 3,
   parameter int EXP_W  = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   fp_div_normalize_if.slave  bus_io
);

   localparam int Q_W = FRAC_W + 3;
   localparam int E_W = EXP_W + 2;
   localparam logic signed [E_W-1:0] E_OVF = E_W'(exp_ones(EXP_W));

   // Hidden bit is dropped after normalization: it is 1 for every legal quotient.
   typedef struct packed {
      logic                  sign;
      logic signed [E_W-1:0] e;
      logic [FRAC_W-1:0]     frac;
      logic                  guard;
      logic                  sticky;
      logic                  zero;
      logic                  dz;
   } s1_payload_t;

   s1_payload_t          s1_d, s1_q;
   logic                 s1_valid_q;

   logic                 out_valid_q;
   logic                 out_sign_q;
   logic [EXP_W-1:0]     out_exp_d,  out_exp_q;
   logic [FRAC_W-1:0]    out_frac_d, out_frac_q;
   fp_flags_t            out_flags_d, out_flags_q;

   logic                 s2_open;
   logic                 s1_open;

   logic [FRAC_W-1:0]    rnd_frac;
   logic                 rnd_carry;
   logic                 rnd_inexact;
   logic signed [E_W-1:0] e_rnd;
   logic                 exp_ovf;
   logic                 exp_unf;

   assign s2_open        = !out_valid_q || bus_io.out_ready;
   assign s1_open        = !s1_valid_q || s2_open;
   assign bus_io.in_ready = s1_open;

   always_comb begin
      s1_d        = '0;
      s1_d.sign   = bus_io.in_sign;
      s1_d.zero   = bus_io.in_zero;
      s1_d.dz     = bus_io.in_dz;
      if (bus_io.in_quot[Q_W-1]) begin
         s1_d.frac   = bus_io.in_quot[Q_W-2:2];
         s1_d.guard  = bus_io.in_quot[1];
         s1_d.sticky = bus_io.in_quot[0] | bus_io.in_rem_nz;
         s1_d.e      = bus_io.in_exp;
      end else begin
         s1_d.frac   = bus_io.in_quot[Q_W-3:1];
         s1_d.guard  = bus_io.in_quot[0];
         s1_d.sticky = bus_io.in_rem_nz;
         s1_d.e      = E_W'(bus_io.in_exp - 1);
      end
   end

   fp_div_round #(
      .FRAC_W (FRAC_W)
   ) u_round (
      .frac_i    (s1_q.frac),
      .guard_i   (s1_q.guard),
      .sticky_i  (s1_q.sticky),
      .frac_o    (rnd_frac),
      .carry_o   (rnd_carry),
      .inexact_o (rnd_inexact)
   );

   assign e_rnd   = s1_q.e + E_W'(rnd_carry);
   assign exp_ovf = !e_rnd[E_W-1] && (e_rnd >= E_OVF);
   assign exp_unf = e_rnd[E_W-1] || (e_rnd == '0);

   always_comb begin
      out_exp_d   = '0;
      out_frac_d  = '0;
      out_flags_d = '0;
      if (s1_q.dz) begin
         out_exp_d      = '1;
         out_flags_d.dz = 1'b1;
      end else if (s1_q.zero) begin
         out_exp_d = '0;
      end else if (exp_ovf) begin
         out_exp_d            = '1;
         out_flags_d.overflow = 1'b1;
         out_flags_d.inexact  = 1'b1;
      end else if (exp_unf) begin
         out_flags_d.underflow = 1'b1;
         out_flags_d.inexact   = 1'b1;
      end else begin
         out_exp_d           = e_rnd[EXP_W-1:0];
         out_frac_d          = rnd_frac;
         out_flags_d.inexact = rnd_inexact;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_q        <= '0;
         out_valid_q <= 1'b0;
         out_sign_q  <= 1'b0;
         out_exp_q   <= '0;
         out_frac_q  <= '0;
         out_flags_q <= '0;
      end else begin
         if (s1_open) begin
            s1_valid_q <= bus_io.in_valid;
         end
         if (s1_open && bus_io.in_valid) begin
            s1_q <= s1_d;
         end
         if (s2_open) begin
            out_valid_q <= s1_valid_q;
         end
         if (s2_open && s1_valid_q) begin
            out_sign_q  <= s1_q.sign;
            out_exp_q   <= out_exp_d;
            out_frac_q  <= out_frac_d;
            out_flags_q <= out_flags_d;
         end
      end
   end

   assign bus_io.out_valid = out_valid_q;
   assign bus_io.out_sign  = out_sign_q;
   assign bus_io.out_exp   = out_exp_q;
   assign bus_io.out_frac  = out_frac_q;
   assign bus_io.out_flags = out_flags_q;

endmodule

// File: tb/tb_fp_div_normalize.sv
// Scoreboarded random and directed bench for fp_div_normalize at default parameters.
// Honours FP_DIV_RNE_EN in its reference model so either build can be checked.
`timescale 1ns/1ps
module tb_fp_div_normalize;

   typedef struct {
      logic       sign;
      logic [3:0] exp;
      logic [2:0] frac;
      logic [3:0] flags;
      int         acc_cyc;
      int         id;
   } exp_t;

   logic clk;
   logic rst_n;
   exp_t sb_q[$];
   int   total, bad, cyc, n_sent, rdy_mode;
   logic lat_chk, stall_seen;

   fp_div_normalize_if #(.FRAC_W(3), .EXP_W(4)) bus ();

   fp_div_normalize #(.FRAC_W(3), .EXP_W(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: treat the quotient as an integer, scale it into [32,63] and round by
   // comparing the discarded part against one half.
   function automatic exp_t model(input int q, input int rem, input int e_in,
                                  input logic s, input logic z, input logic d);
      exp_t r;
      int   v, e, keep, rest;
      logic inex;
      r = '{sign: s, exp: 4'd0, frac: 3'd0, flags: 4'd0, acc_cyc: 0, id: 0};
      if (d) begin
         r.exp = 4'd15; r.flags = 4'b1000;
      end else if (!z) begin
         v = q; e = e_in;
         if (q < 32) begin v = q * 2; e = e_in - 1; end
         v    = v * 2 + rem;
         keep = v / 8;
         rest = v % 8;
         inex = (rest != 0);
`ifdef FP_DIV_RNE_EN
         if (rest > 4 || (rest == 4 && (keep % 2) == 1)) keep = keep + 1;
         if (keep == 16) begin keep = 8; e = e + 1; end
`endif
         if (e >= 15) begin
            r.exp = 4'd15; r.flags = 4'b0101;
         end else if (e <= 0) begin
            r.flags = 4'b0011;
         end else begin
            r.exp = 4'(e); r.frac = 3'(keep % 8); r.flags = {3'b000, inex};
         end
      end
      return r;
   endfunction

   task automatic send(input int q, input int rem, input int e, input logic s,
                       input logic z, input logic d);
      exp_t x;
      int   waited;
      logic ok;
      bus.in_quot   = 6'(q);
      bus.in_rem_nz = rem[0];
      bus.in_exp    = 6'(e);
      bus.in_sign   = s;
      bus.in_zero   = z;
      bus.in_dz     = d;
      bus.in_valid  = 1'b1;
      waited = 0;
      ok     = 1'b0;
      forever begin
         #4;
         if (bus.in_ready) begin ok = 1'b1; break; end
         stall_seen = 1'b1;
         waited++;
         if (waited > 200) break;
         @(negedge clk);
      end
      if (ok) begin
         x = model(q, rem, e, s, z, d);
         x.acc_cyc = cyc;
         x.id      = n_sent;
         n_sent++;
         sb_q.push_back(x);
         $display("send #%0d q=%b rem=%0d exp=%0d sign=%0d zero=%0d dz=%0d cyc=%0d",
                  x.id, 6'(q), rem, e, s, z, d, cyc);
      end else begin
         total++; bad++;
         $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic send_random();
      send($urandom_range(16, 63), $urandom_range(0, 1), int'($urandom_range(0, 21)) - 3,
           1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d beats still pending, required 0", sb_q.size());
      end
   endtask

   // Monitor: pops on each accepted output beat and checks stability across stalls.
   initial begin : monitor
      logic                hold;
      logic [11:0]         held, now;
      exp_t                e;
      hold = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         #4;
         if (!rst_n) begin hold = 1'b0; continue; end
         now = {bus.out_sign, bus.out_exp, bus.out_frac, bus.out_flags};
         if (hold) begin
            total++;
            if (!bus.out_valid || now != held) begin
               bad++;
               $display("FAIL stall_stable: got valid=%0d out=%h, required valid=1 out=%h",
                        bus.out_valid, now, held);
            end
         end
         hold = 1'b0;
         if (bus.out_valid) begin
            if (!bus.out_ready) begin
               hold = 1'b1;
               held = now;
            end else if (sb_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_beat: got out=%h with empty scoreboard, required none", now);
            end else begin
               e = sb_q.pop_front();
               total++;
               if (now != {e.sign, e.exp, e.frac, e.flags}) begin
                  bad++;
                  $display("FAIL beat #%0d: got sign=%0d exp=%0d frac=%b flags=%b, required sign=%0d exp=%0d frac=%b flags=%b",
                           e.id, bus.out_sign, bus.out_exp, bus.out_frac, bus.out_flags,
                           e.sign, e.exp, e.frac, e.flags);
               end else begin
                  $display("recv #%0d sign=%0d exp=%0d frac=%b flags=%b cyc=%0d",
                           e.id, bus.out_sign, bus.out_exp, bus.out_frac, bus.out_flags, cyc);
               end
               if (lat_chk) begin
                  total++;
                  if (cyc - e.acc_cyc != 2) begin
                     bad++;
                     $display("FAIL latency #%0d: got %0d cycles, required 2", e.id, cyc - e.acc_cyc);
                  end
               end
            end
         end
      end
   end

   initial begin : ready_drv
      bus.out_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (rdy_mode == 0)      bus.out_ready = 1'b1;
         else if (rdy_mode == 1) bus.out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   int          dq[13]  = '{6'b100000, 6'b010110, 6'b100110, 6'b100010, 6'b100010, 6'b111110,
                            6'b100000, 6'b100000, 6'b100000, 6'b100110, 6'b110101, 6'b111111,
                            6'b011111};
   int          drem[13] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
   int          dexp[13] = '{7, 7, 7, 7, 7, 7, 15, 0, 7, 7, 14, 14, 1};
   logic [12:0] dsgn     = 13'b0_0101_1000_0010;
   logic [12:0] dzero    = 13'b0_0011_0000_0000;
   logic [12:0] ddz      = 13'b0_0001_0000_0000;

   initial begin : main
      total = 0; bad = 0; n_sent = 0; rdy_mode = 0;
      lat_chk = 1'b0; stall_seen = 1'b0;
      bus.in_valid = 1'b0; bus.in_quot = '0; bus.in_rem_nz = 1'b0; bus.in_exp = '0;
      bus.in_sign = 1'b0; bus.in_zero = 1'b0; bus.in_dz = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (bus.out_valid || {bus.out_sign, bus.out_exp, bus.out_frac, bus.out_flags} != 12'h000) begin
         bad++;
         $display("FAIL reset_state: got valid=%0d out=%h, required valid=0 out=000",
                  bus.out_valid, {bus.out_sign, bus.out_exp, bus.out_frac, bus.out_flags});
      end
      rst_n = 1'b1;
      @(negedge clk);
      #4;
      total++;
      if (!bus.in_ready) begin
         bad++;
         $display("FAIL ready_after_reset: got in_ready=0, required 1");
      end
      @(negedge clk);

      // Directed table streamed back-to-back with the consumer always ready.
      lat_chk = 1'b1;
      for (int i = 0; i < 13; i++)
         send(dq[i], drem[i], dexp[i], dsgn[i], dzero[i], ddz[i]);
      wait_drain();
      lat_chk = 1'b0;

      // Five-beat stream with the consumer stalled for cycles 2-4.
      rdy_mode = 2;
      @(negedge clk);
      stall_seen = 1'b0;
      fork
         begin
            for (int i = 0; i < 5; i++) send_random();
         end
         begin
            for (int c = 0; c < 8; c++) begin
               bus.out_ready = !(c >= 2 && c <= 4);
               @(negedge clk);
            end
         end
      join
      bus.out_ready = 1'b1;
      wait_drain();
      total++;
      if (!stall_seen) begin
         bad++;
         $display("FAIL in_ready_drop: got in_ready never low, required low once both stages full");
      end

      // Reset with both stages occupied.
      bus.out_ready = 1'b0;
      send_random();
      send_random();
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (bus.out_valid || {bus.out_sign, bus.out_exp, bus.out_frac, bus.out_flags} != 12'h000) begin
         bad++;
         $display("FAIL midstream_reset: got valid=%0d out=%h, required valid=0 out=000",
                  bus.out_valid, {bus.out_sign, bus.out_exp, bus.out_frac, bus.out_flags});
      end
      sb_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #4;
         total++;
         if (bus.out_valid) begin
            bad++;
            $display("FAIL stale_beat: got out_valid=1 %0d cycles after reset, required 0", i);
         end
         @(negedge clk);
      end

      // Random traffic with random back-pressure.
      rdy_mode = 1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
         send_random();
      end
      rdy_mode = 0;
      wait_drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fp_div_normalize.md
# fp_div_normalize

Pipelined post-divide normalize/round stage for the FPU divide path. It consumes the raw mantissa quotient, remainder-nonzero indication and pre-computed biased exponent from the mantissa divider array. It produces a normalized, rounded, packed result with exception flags. It has two register stages with a valid/ready handshake on both sides and full throughput.

## Interface
- FRAC_W, 3: stored fraction bits of the result; significand is FRAC_W+1 bits with the hidden bit.
- EXP_W, 4: stored exponent bits; bias = 2^(EXP_W-1)-1 (7 by default).
- Q_W, FRAC_W+3 (derived localparam, not overridable): quotient width.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat this cycle.
- in_quot  in  Q_W  quotient; bit Q_W-1 is the integer bit, the rest are fraction bits.
- in_rem_nz  in  1  divider remainder nonzero.
- in_exp  in  EXP_W+2  signed biased exponent, computed as ea-eb+bias.
- in_sign  in  1  result sign.
- in_zero  in  1  dividend zero; result is exact zero.
- in_dz  in  1  divide by zero; result is infinity.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_sign  out  1
- out_exp  out  EXP_W
- out_frac  out  FRAC_W
- out_flags  out  4  {dz, overflow, underflow, inexact}.

## Operation
- Stage 1 (normalize):
  - If in_quot[Q_W-1]=1: sig = in_quot[Q_W-1:2], guard = in_quot[1], sticky = in_quot[0] | in_rem_nz, e = in_exp.
  - Else: sig = in_quot[Q_W-2:1], guard = in_quot[0], sticky = in_rem_nz, e = in_exp-1.
  - Quotient ratio lies in (0.5,2), so at most one left shift is needed. If both top bits are 0 the input is illegal; output is don't-care except that the handshake must still operate.
- Stage 2 (round/pack):
  - Round to nearest even: up = guard & (sticky | sig[0]).
  - sig+up carrying out of FRAC_W+1 bits gives sig = 1.000…, e = e+1.
  - inexact = guard | sticky.
- Exponent checks, applied after rounding:
  - e >= 2^EXP_W-1: overflow. out_exp = all ones, frac 0, flags overflow|inexact.
  - e <= 0: flush to zero. exp 0, frac 0, flags underflow|inexact. No denormals.
- Specials take priority over arithmetic, with in_dz above in_zero:
  - in_dz: exp all ones, frac 0, flags dz only.
  - in_zero: exp 0, frac 0, flags 0.
- Sign passes through unchanged in every case.
- Exponent arithmetic is performed signed in EXP_W+2 bits; it cannot wrap for legal in_exp.

## Timing
- Latency: accepted beat appears on out_* exactly 2 cycles later, provided out_ready held high.
- Throughput: one beat per cycle.
- Each stage holds a valid bit.
  - A stage loads when it is empty or its contents advance in the same cycle.
  - in_ready = !s1_valid | (!s2_valid | out_ready). This is combinational from out_ready; there is no skid buffer.
- out_* stay stable while out_valid & !out_ready.
- Beats are never dropped or reordered.
- Simultaneous accept and emit in the same cycle is legal at full pipeline.
- Reset, asynchronous and any time including mid-operation:
  - s1_valid = s2_valid = 0; out_valid = 0.
  - out_sign/exp/frac/flags = 0.
  - in_ready = 1 from the first cycle after reset deassertion.
  - In-flight beats are discarded.

## Configuration
- FP_DIV_RNE_EN defined: round to nearest even as above.
- Not defined: truncate (up = 0).
  - Inexact is still reported.
  - Rounding carry and the renormalize path are removed.
  - Overflow/underflow checks use the unrounded e.

## Structure
- Shared package fpu_div_pkg:
  - flags struct typedef {dz, overflow, underflow, inexact}.
  - Stage-1 payload struct {sign, e, sig, guard, sticky, zero, dz}.
  - Bias/all-ones exponent constants as functions of EXP_W.
- Sub-module fp_div_round: combinational rounder (sig, guard, sticky -> rounded sig, carry, inexact). Only the FP_DIV_RNE_EN build contains the rounding logic.
- Top holds the two pipeline registers and the handshake.

## Test plan
All cases use default parameters.
- q=6'b100000, rem_nz=0, exp=7 -> out 2 cycles later: exp 7, frac 000, flags 0.
- q=6'b010110, exp=7 -> left shift: exp 6, frac 011, flags 0.
- Rounding, RNE build:
  - q=6'b100110 -> frac 010, inexact.
  - q=6'b100010 -> frac 000 (tie to even), inexact.
  - q=6'b100010 with rem_nz=1 -> frac 001, inexact.
- Round carry: q=6'b111110, exp=7 -> exp 8, frac 000, inexact.
- Overflow/underflow/specials:
  - exp=15, q=6'b100000 -> exp 15, frac 0, overflow|inexact.
  - exp=0 -> zero, underflow|inexact.
  - in_dz=1 with in_zero=1 -> infinity, dz only.
- Handshake:
  - Stream 5 beats with out_ready low for cycles 2-4 -> in_ready drops once both stages are full; all 5 beats emerge in order with out_* stable while stalled.
  - Assert rst_n low mid-stream -> out_valid 0 immediately; no stale beat after release.
